// File: rtl/tc_b_dn_skew_pkg.sv
// Shared types and default dimensions for the B-operand distribution network.
package tc_b_dn_pkg;

    typedef enum logic {
        TC_B_MODE_BCAST = 1'b0,
        TC_B_MODE_SKEW  = 1'b1
    } tc_b_mode_e;

    localparam int unsigned TC_B_NUM_TILE   = 16;
    localparam int unsigned TC_B_DW_DATA    = 16;
    localparam int unsigned TC_B_N_PE       = 4;
    localparam int unsigned TC_B_FIFO_DEPTH = 4;
    localparam int unsigned TC_B_STALL_W    = 16;

endpackage

// File: rtl/tc_b_dn_skew_if.sv
// Row handshake bundle: B-buffer side (in_*) and PE-array side (out_*).
interface tc_b_dn_skew_if
    import tc_b_dn_pkg::*;
#(
    parameter int unsigned NUM_TILE = TC_B_NUM_TILE,
    parameter int unsigned DW_DATA  = TC_B_DW_DATA,
    parameter int unsigned N_PE     = TC_B_N_PE
);
    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_TILE*DW_DATA-1:0]       in_b;
    logic                              out_ready;
    logic [N_PE-1:0]                   out_valid;
    logic [N_PE*NUM_TILE*DW_DATA-1:0]  out_b;

    // Distribution network side
    modport slave (
        input  in_valid, in_b, out_ready,
        output in_ready, out_valid, out_b
    );

    // Environment side (B buffer producer and PE array consumer)
    modport master (
        output in_valid, in_b, out_ready,
        input  in_ready, out_valid, out_b
    );
endinterface

// File: rtl/tc_b_dn_skew_row_fifo.sv
// Row FIFO with full/empty flags and synchronous clear; pointers carry a wrap bit.
module tc_b_row_fifo
    import tc_b_dn_pkg::*;
#(
    parameter int unsigned WIDTH = TC_B_NUM_TILE * TC_B_DW_DATA,
    parameter int unsigned DEPTH = TC_B_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr    = i_push && !o_full && !i_clr;
    assign w_rd    = i_pop && !o_empty && !i_clr;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/tc_b_dn_skew.sv
// B-operand distribution: row FIFO feeding N_PE stages in broadcast or skew mode.
// Optional stall counter port enabled by defining TC_B_DN_STALL_CNT_EN.
module tc_b_dn_skew
    import tc_b_dn_pkg::*;
#(
    parameter int unsigned NUM_TILE   = TC_B_NUM_TILE,
    parameter int unsigned DW_DATA    = TC_B_DW_DATA,
    parameter int unsigned N_PE       = TC_B_N_PE,
    parameter int unsigned FIFO_DEPTH = TC_B_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 flush,
    tc_b_dn_skew_if.slave        bus,
    output logic                 busy
`ifdef TC_B_DN_STALL_CNT_EN
    ,
    output logic [TC_B_STALL_W-1:0] stall_cnt
`endif
);
    localparam int unsigned ROW_W = NUM_TILE * DW_DATA;

    logic [ROW_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_adv;
    logic             w_pop;

    tc_b_mode_e       r_mode_q;
    logic [ROW_W-1:0] r_stage_b [N_PE];
    logic [N_PE-1:0]  r_stage_v;

    // No push-through when full: in_ready ignores a same-cycle pop.
    assign bus.in_ready = !w_full && !flush;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_adv        = bus.out_ready && !flush;
    assign w_pop        = w_adv && !w_empty;

    tc_b_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_data  (bus.in_b),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage_v <= '0;
            for (int unsigned p = 0; p < N_PE; p++) r_stage_b[p] <= '0;
        end else if (flush) begin
            r_stage_v <= '0;
        end else if (w_adv) begin
            if (r_mode_q == TC_B_MODE_BCAST) begin
                r_stage_v <= {N_PE{w_pop}};
                for (int unsigned p = 0; p < N_PE; p++) begin
                    if (w_pop) r_stage_b[p] <= w_head;
                end
            end else begin
                // Bubbles shift like rows; stage 0 data holds when nothing is popped.
                r_stage_v[0] <= w_pop;
                if (w_pop) r_stage_b[0] <= w_head;
                for (int unsigned p = 1; p < N_PE; p++) begin
                    r_stage_v[p] <= r_stage_v[p-1];
                    r_stage_b[p] <= r_stage_b[p-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_q <= TC_B_MODE_BCAST;
        end else if (!busy) begin
            r_mode_q <= tc_b_mode_e'(mode);
        end
    end

    assign busy          = !w_empty || (|r_stage_v);
    assign bus.out_valid = r_stage_v;

    for (genvar gp = 0; gp < N_PE; gp++) begin : g_out
        assign bus.out_b[gp*ROW_W +: ROW_W] = r_stage_b[gp];
    end

`ifdef TC_B_DN_STALL_CNT_EN
    logic [TC_B_STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (!bus.out_ready && (|r_stage_v) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tc_b_dn_skew.sv
// Directed bench for tc_b_dn_skew with a per-PE row scoreboard.
`timescale 1ns/1ps
module tb_tc_b_dn_skew;
    import tc_b_dn_pkg::*;

    localparam int NT = 16;
    localparam int DW = 16;
    localparam int NP = 4;
    localparam int FD = 4;
    localparam int RW = NT * DW;

    typedef logic [RW-1:0] row_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mode = 1'b0;
    logic flush = 1'b0;
    logic busy;
`ifdef TC_B_DN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    tc_b_dn_skew_if #(.NUM_TILE(NT), .DW_DATA(DW), .N_PE(NP)) bus ();

    tc_b_dn_skew #(
        .NUM_TILE   (NT),
        .DW_DATA    (DW),
        .N_PE       (NP),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
`ifdef TC_B_DN_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    row_t exp_q [NP][$];
    row_t mon_got;
    row_t mon_want;

    function automatic row_t mk_row(int base);
        row_t r;
        for (int i = 0; i < NT; i++) r[i*DW +: DW] = 16'(base + i);
        return r;
    endfunction

    task automatic chk(string nm, row_t act, row_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: a row is consumed when presented valid with out_ready high.
    always @(negedge clk) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                if (bus.out_valid[p] && bus.out_ready) begin
                    mon_got = bus.out_b[p*RW +: RW];
                    n_chk++;
                    if (exp_q[p].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected pe=%0d actual=%0h expected=none", p, mon_got);
                    end else begin
                        mon_want = exp_q[p].pop_front();
                        if (mon_got !== mon_want) begin
                            n_fail++;
                            $display("FAIL sb_row pe=%0d actual=%0h expected=%0h", p, mon_got, mon_want);
                        end
                    end
                end
            end
        end
    end

    // One clock: record an accepted push, then step to just after the rising edge.
    task automatic tick();
        bit fl;
        @(negedge clk);
        #1;
        fl = flush;
        if (bus.in_valid && bus.in_ready) begin
            for (int p = 0; p < NP; p++) exp_q[p].push_back(bus.in_b);
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (fl) for (int p = 0; p < NP; p++) exp_q[p].delete();
    endtask

    task automatic drain();
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        chk("drain_bound", row_t'(k < 40), row_t'(1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] skew_v [9];
    int base;

    initial begin
        skew_v = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        bus.in_valid  = 1'b0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", row_t'(bus.out_valid), row_t'(0));
        chk("rst_out_b", row_t'(|bus.out_b), row_t'(0));
        chk("rst_in_ready", row_t'(bus.in_ready), row_t'(1));
        chk("rst_busy", row_t'(busy), row_t'(0));
`ifdef TC_B_DN_STALL_CNT_EN
        chk("rst_stall_cnt", row_t'(stall_cnt), row_t'(0));
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Broadcast: two rows, both on every PE one edge after push
        mode = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_b = mk_row(0);
        tick();
        chk("bc_v0", row_t'(bus.out_valid), row_t'(4'h0));
        bus.in_b = mk_row(16);
        tick();
        chk("bc_v1", row_t'(bus.out_valid), row_t'(4'hF));
        chk("bc_pe3_row0", bus.out_b[3*RW +: RW], mk_row(0));
        bus.in_valid = 1'b0;
        tick();
        chk("bc_v2", row_t'(bus.out_valid), row_t'(4'hF));
        chk("bc_pe0_row1", bus.out_b[0 +: RW], mk_row(16));
        tick();
        chk("bc_v3", row_t'(bus.out_valid), row_t'(4'h0));
        chk("bc_busy", row_t'(busy), row_t'(0));

        // Skew: four back-to-back rows ramp in and drain out
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = (i < 4);
            bus.in_b = mk_row(100 + 16 * i);
            tick();
            chk($sformatf("skew_v%0d", i), row_t'(bus.out_valid), row_t'(skew_v[i]));
            if (i == 4) chk("skew_pe2_r1", bus.out_b[2*RW +: RW], mk_row(116));
        end
        chk("skew_busy", row_t'(busy), row_t'(0));

        // Backpressure: one row parked in stages, five offered with out_ready low
        mode = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_b = mk_row(500);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("bp_parked_v", row_t'(bus.out_valid), row_t'(4'hF));
        bus.out_ready = 1'b0;
        base = n_acc;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = (n_acc - base) < 5;
            bus.in_b = mk_row(600 + 16 * (n_acc - base));
            tick();
        end
        chk("bp_accepted", row_t'(n_acc - base), row_t'(4));
        chk("bp_in_ready", row_t'(bus.in_ready), row_t'(0));
        chk("bp_frozen_v", row_t'(bus.out_valid), row_t'(4'hF));
        chk("bp_frozen_pe0", bus.out_b[0 +: RW], mk_row(500));
        chk("bp_frozen_pe3", bus.out_b[3*RW +: RW], mk_row(500));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if ((n_acc - base) == 5 && !busy) break;
            bus.in_valid = (n_acc - base) < 5;
            bus.in_b = mk_row(600 + 16 * (n_acc - base));
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_all_accepted", row_t'(n_acc - base), row_t'(5));
        chk("bp_busy", row_t'(busy), row_t'(0));
        for (int p = 0; p < NP; p++)
            chk($sformatf("bp_leftover_pe%0d", p), row_t'(exp_q[p].size()), row_t'(0));

        // Flush: skew with three rows in stages and two in the FIFO
        mode = 1'b1;
        tick();
        base = n_acc;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_b = mk_row(1000 + 16 * c);
            bus.out_ready = (c < 4);
            tick();
        end
        chk("fl_pre_v", row_t'(bus.out_valid), row_t'(4'h7));
        chk("fl_pre_acc", row_t'(n_acc - base), row_t'(5));
        flush = 1'b1;
        bus.in_b = mk_row(2000);
        bus.out_ready = 1'b1;
        #1;
        chk("fl_in_ready", row_t'(bus.in_ready), row_t'(0));
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_v", row_t'(bus.out_valid), row_t'(4'h0));
        chk("fl_busy", row_t'(busy), row_t'(0));
        chk("fl_not_accepted", row_t'(n_acc - base), row_t'(5));
        tick();
        chk("fl_fifo_empty", row_t'(bus.out_valid), row_t'(4'h0));

        // Mode change while busy: stream stays broadcast until drained
        mode = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_b = mk_row(3000);
        tick();
        mode = 1'b1;
        bus.in_b = mk_row(3016);
        tick();
        chk("mc_v1", row_t'(bus.out_valid), row_t'(4'hF));
        bus.in_b = mk_row(3032);
        tick();
        chk("mc_v2", row_t'(bus.out_valid), row_t'(4'hF));
        bus.in_valid = 1'b0;
        tick();
        chk("mc_v3", row_t'(bus.out_valid), row_t'(4'hF));
        tick();
        chk("mc_v4", row_t'(bus.out_valid), row_t'(4'h0));
        chk("mc_busy", row_t'(busy), row_t'(0));
        tick();
        bus.in_valid = 1'b1;
        bus.in_b = mk_row(3100);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mc_skew_now", row_t'(bus.out_valid), row_t'(4'h1));
        drain();

`ifdef TC_B_DN_STALL_CNT_EN
        // Stall counter: count, saturate, clear
        mode = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_b = mk_row(4000);
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        repeat (10) tick();
        chk("sc_ten", row_t'(stall_cnt), row_t'(10));
        repeat (70000) tick();
        chk("sc_sat", row_t'(stall_cnt), row_t'(16'hFFFF));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sc_flush", row_t'(stall_cnt), row_t'(0));
        bus.out_ready = 1'b1;
`endif

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
